// File: rtl/race_game_ctrl.sv
// race_game_ctrl: game sequencing, collision, scoring and speed control
// for a vertical car-dodging game driven by per-frame ticks.
module race_game_ctrl #(
  parameter int CAR_WIDTH        = 20,
  parameter int CAR_HEIGHT       = 40,
  parameter int PLAYER_Y         = 400,
  parameter int COUNTDOWN_FRAMES = 180,
  parameter int CRASH_FRAMES     = 120,
  parameter int SPEED_STEP       = 10,
  parameter int MAX_SPEED        = 6,
  parameter int INIT_LIVES       = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        btn_start,
  input  logic [9:0]  car_user_x,
  input  logic [9:0]  car2_x,
  input  logic [9:0]  car2_y,
  input  logic [9:0]  car3_x,
  input  logic [9:0]  car3_y,
  output logic        internal_reset,
  output logic        end_game,
  output logic [2:0]  speed,
  output logic [13:0] score,
  output logic [13:0] high_score,
  output logic [1:0]  lives,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COUNTDOWN = 3'd1,
    RUN       = 3'd2,
    CRASH     = 3'd3,
    GAME_OVER = 3'd4
  } state_e;

  localparam logic [13:0] SCORE_MAX = 14'd9999;
  localparam logic [10:0] W         = 11'(CAR_WIDTH);
  localparam logic [10:0] H         = 11'(CAR_HEIGHT);
  localparam logic [10:0] PY        = 11'(PLAYER_Y);
  localparam logic [15:0] CD_LAST   = 16'(COUNTDOWN_FRAMES - 1);
  localparam logic [15:0] CR_LAST   = 16'(CRASH_FRAMES - 1);
  localparam logic [13:0] STEP      = 14'(SPEED_STEP);
  localparam logic [2:0]  SPD_MAX   = 3'(MAX_SPEED);
  localparam logic [1:0]  LIVES0    = 2'(INIT_LIVES);

  state_e      state_q;
  logic        btn_q;
  logic [15:0] cnt_q;
  logic [9:0]  y2_q;
  logic [9:0]  y3_q;
  logic [13:0] rem_q;
  logic        bump_q;
  logic [2:0]  spd_q;

  logic        start_edge;
  logic        hit_any;
  logic [1:0]  pass_n;
  logic [1:0]  add;
  logic [13:0] room;
  logic [13:0] rem_sum;
  logic [2:0]  spd_nxt;

  // Overlap test widened to 11 bits so x+W and y+H cannot wrap
  function automatic logic hit(
    input logic [9:0] ux,
    input logic [9:0] ex,
    input logic [9:0] ey
  );
    logic [10:0] u;
    logic [10:0] x;
    logic [10:0] y;
    u = {1'b0, ux};
    x = {1'b0, ex};
    y = {1'b0, ey};
    return (u < x + W) && (x < u + W) &&
           (y < PY + H) && (PY < y + H);
  endfunction

  always_comb begin
    start_edge = btn_start & ~btn_q;
    hit_any    = hit(car_user_x, car2_x, car2_y) |
                 hit(car_user_x, car3_x, car3_y);
    pass_n     = {1'b0, car2_y < y2_q} + {1'b0, car3_y < y3_q};
    room       = SCORE_MAX - score;
    add        = (room < {12'd0, pass_n}) ? room[1:0] : pass_n;
    rem_sum    = rem_q + {12'd0, add};
    spd_nxt    = (bump_q && spd_q < SPD_MAX) ? spd_q + 3'd1 : spd_q;
  end

  assign state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      btn_q          <= 1'b0;
      cnt_q          <= '0;
      y2_q           <= '0;
      y3_q           <= '0;
      rem_q          <= '0;
      bump_q         <= 1'b0;
      spd_q          <= '0;
      internal_reset <= 1'b0;
      end_game       <= 1'b1;
      speed          <= '0;
      score          <= '0;
      high_score     <= '0;
      lives          <= LIVES0;
    end else begin
      btn_q          <= btn_start;
      internal_reset <= 1'b0;
      bump_q         <= 1'b0;
      spd_q          <= spd_nxt;
      if (frame_tick) begin
        y2_q <= car2_y;
        y3_q <= car3_y;
      end
      unique case (state_q)
        IDLE, GAME_OVER: begin
          if (start_edge) begin
            state_q        <= COUNTDOWN;
            internal_reset <= 1'b1;
            score          <= '0;
            lives          <= LIVES0;
            spd_q          <= 3'd1;
            rem_q          <= '0;
            cnt_q          <= '0;
          end
        end
        COUNTDOWN: begin
          if (frame_tick) begin
            if (cnt_q == CD_LAST) begin
              state_q  <= RUN;
              cnt_q    <= '0;
              end_game <= 1'b0;
              speed    <= spd_nxt;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
        end
        RUN: begin
          speed <= spd_nxt;
          if (frame_tick) begin
            if (hit_any) begin
              state_q  <= CRASH;
              lives    <= lives - 2'd1;
              cnt_q    <= '0;
              end_game <= 1'b1;
              speed    <= '0;
            end else begin
              score <= score + {12'd0, add};
              // Remainder tracks progress toward the next speed step
              if (rem_sum >= STEP) begin
                rem_q  <= rem_sum - STEP;
                bump_q <= 1'b1;
              end else begin
                rem_q <= rem_sum;
              end
            end
          end
        end
        CRASH: begin
          if (frame_tick) begin
            if (cnt_q == CR_LAST) begin
              cnt_q <= '0;
              if (lives != 2'd0) begin
                state_q        <= COUNTDOWN;
                internal_reset <= 1'b1;
              end else begin
                state_q <= GAME_OVER;
                if (score > high_score) high_score <= score;
              end
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_race_game_ctrl.sv
// tb_race_game_ctrl: directed checks of game flow, collision,
// scoring, speed, high score and asynchronous reset.
module tb_race_game_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic        btn_start = 1'b0;
  logic [9:0]  car_user_x = 10'd200;
  logic [9:0]  car2_x = 10'd600;
  logic [9:0]  car2_y = 10'd0;
  logic [9:0]  car3_x = 10'd700;
  logic [9:0]  car3_y = 10'd0;
  logic        internal_reset;
  logic        end_game;
  logic [2:0]  speed;
  logic [13:0] score;
  logic [13:0] high_score;
  logic [1:0]  lives;
  logic [2:0]  state;

  int n_tests = 0;
  int n_fail  = 0;

  race_game_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .frame_tick     (frame_tick),
    .btn_start      (btn_start),
    .car_user_x     (car_user_x),
    .car2_x         (car2_x),
    .car2_y         (car2_y),
    .car3_x         (car3_x),
    .car3_y         (car3_y),
    .internal_reset (internal_reset),
    .end_game       (end_game),
    .speed          (speed),
    .score          (score),
    .high_score     (high_score),
    .lives          (lives),
    .state          (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic tick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press();
    @(negedge clk);
    btn_start = 1'b1;
    @(negedge clk);
    btn_start = 1'b0;
  endtask

  task automatic pass2();
    car2_y = 10'd479;
    car3_y = 10'd470;
    tick();
    car2_y = 10'd0;
    car3_y = 10'd2;
    tick();
  endtask

  task automatic pass_one();
    car2_y = 10'd479;
    tick();
    car2_y = 10'd0;
    tick();
  endtask

  task automatic park2();
    car2_x = 10'd600;
    car2_y = 10'd0;
  endtask

  initial begin
    #12;
    chk("rst_state", 32'(state), 0);
    chk("rst_ir", 32'(internal_reset), 0);
    chk("rst_end", 32'(end_game), 1);
    chk("rst_speed", 32'(speed), 0);
    chk("rst_score", 32'(score), 0);
    chk("rst_hs", 32'(high_score), 0);
    chk("rst_lives", 32'(lives), 3);
    @(negedge clk);
    rst_n = 1'b1;

    press();
    chk("start_state", 32'(state), 1);
    chk("start_ir", 32'(internal_reset), 1);
    chk("start_end", 32'(end_game), 1);
    cyc();
    chk("ir_one_clk", 32'(internal_reset), 0);
    ticks(179);
    chk("cd_179", 32'(state), 1);
    tick();
    chk("run_state", 32'(state), 2);
    chk("run_end", 32'(end_game), 0);
    chk("run_speed", 32'(speed), 1);

    pass2();
    chk("pass2_score", 32'(score), 2);
    for (int i = 0; i < 4; i++) pass2();
    chk("score10", 32'(score), 10);
    chk("speed_lag", 32'(speed), 1);
    cyc();
    chk("speed2", 32'(speed), 2);

    car2_x = 10'd220;
    car2_y = 10'd400;
    tick();
    chk("touch_state", 32'(state), 2);
    chk("touch_lives", 32'(lives), 3);
    chk("touch_score", 32'(score), 10);
    car2_x = 10'd219;
    tick();
    chk("ov_state", 32'(state), 3);
    chk("ov_lives", 32'(lives), 2);
    chk("ov_speed", 32'(speed), 0);
    chk("ov_end", 32'(end_game), 1);
    chk("ov_score", 32'(score), 10);

    park2();
    ticks(119);
    chk("crash_119", 32'(state), 3);
    tick();
    chk("recd_state", 32'(state), 1);
    chk("recd_ir", 32'(internal_reset), 1);
    chk("recd_score", 32'(score), 10);
    chk("recd_lives", 32'(lives), 2);
    cyc();
    chk("recd_ir_off", 32'(internal_reset), 0);
    ticks(180);
    chk("rerun_state", 32'(state), 2);
    chk("rerun_speed", 32'(speed), 2);

    for (int i = 0; i < 7; i++) pass2();
    pass_one();
    chk("score25", 32'(score), 25);
    cyc();
    chk("speed3", 32'(speed), 3);

    car2_x = 10'd210;
    car2_y = 10'd390;
    tick();
    chk("crash2_state", 32'(state), 3);
    chk("crash2_lives", 32'(lives), 1);
    chk("crash2_speed", 32'(speed), 0);
    park2();
    ticks(120);
    ticks(180);
    chk("run3_state", 32'(state), 2);
    car2_x = 10'd210;
    car2_y = 10'd390;
    tick();
    chk("crash3_lives", 32'(lives), 0);
    park2();
    ticks(120);
    chk("go_state", 32'(state), 4);
    chk("go_hs", 32'(high_score), 25);
    chk("go_end", 32'(end_game), 1);
    chk("go_speed", 32'(speed), 0);

    press();
    chk("restart_state", 32'(state), 1);
    chk("restart_score", 32'(score), 0);
    chk("restart_lives", 32'(lives), 3);
    chk("restart_hs", 32'(high_score), 25);
    ticks(180);
    chk("run4_speed", 32'(speed), 1);
    for (int i = 0; i < 25; i++) pass2();
    chk("score50", 32'(score), 50);
    cyc();
    chk("speed_cap", 32'(speed), 6);
    press();
    chk("ignore_start", 32'(state), 2);

    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(state), 0);
    chk("arst_score", 32'(score), 0);
    chk("arst_hs", 32'(high_score), 0);
    chk("arst_speed", 32'(speed), 0);
    chk("arst_end", 32'(end_game), 1);
    chk("arst_lives", 32'(lives), 3);
    chk("arst_ir", 32'(internal_reset), 0);
    @(negedge clk);
    rst_n = 1'b1;

    press();
    ticks(180);
    for (int i = 0; i < 4999; i++) pass2();
    chk("score9998", 32'(score), 9998);
    for (int i = 0; i < 3; i++) pass2();
    chk("score_sat", 32'(score), 9999);
    cyc();
    chk("speed_sat", 32'(speed), 6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/race_game_ctrl.md
RACE_GAME_CTRL -- requirements
Module: race_game_ctrl

Interface
REQ-001 Parameter CAR_WIDTH, default 20, car width in pixels for collision.
REQ-002 Parameter CAR_HEIGHT, default 40, car height in pixels for collision.
REQ-003 Parameter PLAYER_Y, default 400, fixed top y of player car.
REQ-004 Parameter COUNTDOWN_FRAMES, default 180, frames spent in COUNTDOWN.
REQ-005 Parameter CRASH_FRAMES, default 120, frames spent in CRASH.
REQ-006 Parameter SPEED_STEP, default 10, score points per speed increment.
REQ-007 Parameter MAX_SPEED, default 6, speed ceiling (≤7).
REQ-008 Parameter INIT_LIVES, default 3, lives at game start (1..3).
REQ-009 clk  in  1  system clock; all logic on posedge clk.
REQ-010 rst_n  in  1  reset, asynchronous, active-low.
REQ-011 frame_tick  in  1  one-clk pulse per frame, already synchronous to clk.
REQ-012 btn_start  in  1  debounced start button level, synchronous to clk.
REQ-013 car_user_x  in  10  player car left x.
REQ-014 car2_x, car2_y, car3_x, car3_y  in  10 each  enemy car top-left positions.
REQ-015 internal_reset  out  1  one-clk pulse re-initialising the car-position datapath.
REQ-016 end_game  out  1  freezes player movement (drives END).
REQ-017 speed  out  3  enemy fall speed (drives SPEED).
REQ-018 score  out  14  current score, 0..9999.
REQ-019 high_score  out  14  best score since rst_n.
REQ-020 lives  out  2  remaining lives.
REQ-021 state  out  3  IDLE=0, COUNTDOWN=1, RUN=2, CRASH=3, GAME_OVER=4.

Function
REQ-022 start_edge SHALL be btn_start high with its value one clk earlier low (one register stage).
REQ-023 IDLE or GAME_OVER + start_edge -> COUNTDOWN; score:=0, lives:=INIT_LIVES, speed:=1, frame counter:=0.
REQ-024 COUNTDOWN: frame counter increments per frame_tick; on the tick making it COUNTDOWN_FRAMES -> RUN.
REQ-025 RUN, on frame_tick only: collision check on all enemy cars, then pass detection.
REQ-026 Collision with enemy (ex,ey): car_user_x < ex+CAR_WIDTH AND ex < car_user_x+CAR_WIDTH AND ey < PLAYER_Y+CAR_HEIGHT AND PLAYER_Y < ey+CAR_HEIGHT; compare at 11 bits, no overflow.
REQ-027 Collision -> CRASH, lives decremented once (even if both cars collide), no score change that tick.
REQ-028 Pass: enemy y on this tick < y latched on previous frame_tick (wrap to top); +1 per car, +2 if both; latches update every frame_tick in all states.
REQ-029 score SHALL saturate at 9999.
REQ-030 speed = min(1 + score/SPEED_STEP, MAX_SPEED), via step counter (no divider), updated the cycle after score changes.
REQ-031 CRASH: counts CRASH_FRAMES frame_ticks; expiry with lives>0 -> COUNTDOWN (score/speed kept); lives=0 -> GAME_OVER.
REQ-032 Entering GAME_OVER: high_score := score if score > high_score.
REQ-033 internal_reset SHALL be high for exactly the first clk in which state=COUNTDOWN, on every COUNTDOWN entry, else low.
REQ-034 end_game SHALL be 0 only in RUN; speed SHALL be 0 outside RUN, and retained value is restored on RUN re-entry.
REQ-035 start_edge in COUNTDOWN, RUN or CRASH SHALL be ignored.
REQ-036 All outputs registered; state change occurs on the clk edge sampling the causing event.

Reset
REQ-037 rst_n low: state=IDLE, internal_reset=0, end_game=1, speed=0, score=0, high_score=0, lives=INIT_LIVES, counters and y latches=0, immediately and mid-game.

Verification
REQ-038 Reset, pulse btn_start -> state 1, internal_reset one clk, end_game=1; after 180 frame_ticks state 2, end_game=0, speed=1.
REQ-039 RUN, car_user_x=200, car2=(210,390) on tick -> state 3, lives 3->2, speed 0; 120 ticks later state 1 with internal_reset pulse, score kept.
REQ-040 RUN, car2_y 479->0 and car3_y 470->2 on same tick, no collision -> score +2; at score 10 -> speed 2; score never exceeds 9999, speed stays 6.
REQ-041 Three crashes with score 25 -> GAME_OVER, high_score=25; btn_start -> COUNTDOWN, score 0, lives 3, high_score 25.
REQ-042 Edge case: car2_x=car_user_x+20 (touching) -> no collision; car2_x=car_user_x+19 -> collision.
REQ-043 rst_n asserted mid-RUN with score 50 -> all outputs at reset values same cycle, asynchronously.
